// File: rtl/pkt_rr_arbiter_pkg.sv
// Shared types and constants for the packet-granular round-robin arbiter.
package pkt_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int EMPTY_W = 6;
  localparam int CNT_W   = 32;

endpackage

// File: rtl/pkt_rr_arbiter_rr_pick.sv
// Round-robin picker: first requester strictly after ptr, wrapping modulo NUM_IN.
module rr_pick
  import pkt_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);

  // Scan from the farthest candidate to the nearest so the nearest hit is the last write.
  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = NUM_IN; k >= 1; k--) begin
      c = (int'(ptr) + k) % NUM_IN;
      if (req[c[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pkt_rr_arbiter.sv
// Merges NUM_IN Avalon-ST packet streams into one, round-robin per packet.
// Optional per-port packet counters and stall counter when PKT_ARB_STATS_EN is defined.
module pkt_rr_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int NUM_IN           = 4,
  parameter int SYMBOLS_PER_BEAT = 64,
  parameter int BITS_PER_SYMBOL  = 8,
  localparam int DW              = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL,
  localparam int IDX_W           = $clog2(NUM_IN)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_IN*DW-1:0]        in_data,
  input  logic [NUM_IN-1:0]           in_valid,
  output logic [NUM_IN-1:0]           in_ready,
  input  logic [NUM_IN-1:0]           in_startofpacket,
  input  logic [NUM_IN-1:0]           in_endofpacket,
  input  logic [NUM_IN*EMPTY_W-1:0]   in_empty,
  output logic [DW-1:0]               out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_startofpacket,
  output logic                        out_endofpacket,
  output logic [EMPTY_W-1:0]          out_empty,
  input  logic                        out_almost_full,
  output logic [IDX_W-1:0]            grant_idx,
  output logic                        busy,
`ifdef PKT_ARB_STATS_EN
  output logic [NUM_IN*CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]            stall_cycles,
`endif
  output logic                        sop_err
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               eop_accept;

  logic [DW-1:0]      data_arr  [NUM_IN];
  logic [EMPTY_W-1:0] empty_arr [NUM_IN];

  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign data_arr[i]  = in_data[i*DW +: DW];
    assign empty_arr[i] = in_empty[i*EMPTY_W +: EMPTY_W];
  end

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_rr_pick (
    .req   (in_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A beat moves when valid and ready are both high on a rising edge; valid never
  // depends on ready. In XFER the granted port is wired straight through, so the
  // handshake is exactly the source's valid against the sink's ready.
  always_comb begin
    in_ready  = '0;
    out_valid = 1'b0;
    if (state == XFER) begin
      out_valid           = in_valid[grant_idx];
      in_ready[grant_idx] = out_ready;
    end
  end

  assign out_data          = data_arr[grant_idx];
  assign out_empty         = empty_arr[grant_idx];
  assign out_startofpacket = in_startofpacket[grant_idx];
  assign out_endofpacket   = in_endofpacket[grant_idx];

  assign eop_accept = (state == XFER) && in_valid[grant_idx] && out_ready
                      && in_endofpacket[grant_idx];
  assign busy       = (state == XFER);

  // almost_full only gates the start of a packet; a granted packet always runs to EOP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_IN - 1);
      grant_idx <= '0;
      sop_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!out_almost_full && pick_found) begin
            grant_idx <= pick_idx;
            state     <= XFER;
            if (!in_startofpacket[pick_idx]) begin
              sop_err <= 1'b1;
            end
          end
        end
        XFER: begin
          if (eop_accept) begin
            rr_ptr <= grant_idx;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef PKT_ARB_STATS_EN
  logic [CNT_W-1:0] cnt [NUM_IN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) begin
        cnt[i] <= '0;
      end
      stall_cycles <= '0;
    end else begin
      if (eop_accept) begin
        cnt[grant_idx] <= cnt[grant_idx] + 1'b1;
      end
      if ((state == IDLE) && (|in_valid) && out_almost_full) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
    assign pkt_count[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// Directed bench for pkt_rr_arbiter: source queues, packet-level model, beat scoreboard.
`timescale 1ns/1ps
module tb_pkt_rr_arbiter;
  import pkt_arb_pkg::*;

  localparam int NUM_IN = 4;
  localparam int DW     = 512;
  localparam int IDX_W  = 2;
  localparam int SB_W   = 40;

  typedef struct {
    logic [31:0] tag;
    logic        sop;
    logic        eop;
    logic [5:0]  empty;
  } beat_t;

  // ---------------- clock / reset / DUT ----------------
  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_IN*DW-1:0]      in_data;
  logic [NUM_IN-1:0]         in_valid;
  logic [NUM_IN-1:0]         in_ready;
  logic [NUM_IN-1:0]         in_startofpacket;
  logic [NUM_IN-1:0]         in_endofpacket;
  logic [NUM_IN*6-1:0]       in_empty;
  logic [DW-1:0]             out_data;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_startofpacket;
  logic                      out_endofpacket;
  logic [5:0]                out_empty;
  logic                      out_almost_full;
  logic [IDX_W-1:0]          grant_idx;
  logic                      busy;
  logic                      sop_err;
`ifdef PKT_ARB_STATS_EN
  logic [NUM_IN*32-1:0]      pkt_count;
  logic [31:0]               stall_cycles;
`endif

  always #5 clk = ~clk;

  pkt_rr_arbiter #(
    .NUM_IN           (NUM_IN),
    .SYMBOLS_PER_BEAT (64),
    .BITS_PER_SYMBOL  (8)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .out_almost_full   (out_almost_full),
    .grant_idx         (grant_idx),
    .busy              (busy),
`ifdef PKT_ARB_STATS_EN
    .pkt_count         (pkt_count),
    .stall_cycles      (stall_cycles),
`endif
    .sop_err           (sop_err)
  );

  // ---------------- bench state ----------------
  beat_t             src_q [NUM_IN][$];
  logic [SB_W-1:0]   exp_q [$];
  int                sop_ports [$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;

  // packet-level model: who owns the output, who was served last
  int                m_owner;
  int                m_last;
  int                m_gidx;
  bit                m_sop_err;
  int unsigned       m_cnt [NUM_IN];
  int unsigned       m_stall;

  logic [NUM_IN-1:0] s_valid;
  logic [NUM_IN-1:0] s_sop;
  logic              s_afull;
  bit                s_acc;
  bit                s_acc_eop;

  logic              o_valid;
  logic              o_acc;
  logic              o_sop;
  logic              o_eop;
  logic              o_busy;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic int rr_next(int last, logic [NUM_IN-1:0] v);
    int p;
    for (int k = 1; k <= NUM_IN; k++) begin
      p = (last + k) % NUM_IN;
      if (v[p]) return p;
    end
    return -1;
  endfunction

  function automatic beat_t mk_beat(int port, int pkt, int b, int nb, bit first_sop);
    beat_t bt;
    bt.tag   = 32'(port * 256 + pkt * 16 + b);
    bt.sop   = (b == 0) && first_sop;
    bt.eop   = (b == nb - 1);
    bt.empty = bt.eop ? 6'(nb + port) : 6'd0;
    return bt;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_pkt(int port, int pkt, int nb, bit first_sop);
    for (int b = 0; b < nb; b++) src_q[port].push_back(mk_beat(port, pkt, b, nb, first_sop));
  endtask

  task automatic expect_pkt(int port, int pkt, int nb, bit first_sop);
    beat_t bt;
    for (int b = 0; b < nb; b++) begin
      bt = mk_beat(port, pkt, b, nb, first_sop);
      exp_q.push_back({bt.sop, bt.eop, bt.empty, bt.tag});
    end
  endtask

  task automatic drive();
    beat_t bt;
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_q[i].size() > 0) begin
        bt = src_q[i][0];
        in_valid[i]            = 1'b1;
        in_data[i*DW +: DW]    = DW'(bt.tag);
        in_startofpacket[i]    = bt.sop;
        in_endofpacket[i]      = bt.eop;
        in_empty[i*6 +: 6]     = bt.empty;
      end else begin
        in_valid[i]            = 1'b0;
        in_data[i*DW +: DW]    = '0;
        in_startofpacket[i]    = 1'b0;
        in_endofpacket[i]      = 1'b0;
        in_empty[i*6 +: 6]     = '0;
      end
    end
  endtask

  // ---------------- compare (runs at negedge every cycle) ----------------
  task automatic check_cycle();
    logic [NUM_IN-1:0] e_ready;
    logic              e_valid;
    logic [SB_W-1:0]   e;
    e_ready = '0;
    e_valid = 1'b0;
    if (m_owner >= 0) begin
      e_valid          = in_valid[m_owner];
      e_ready[m_owner] = out_ready;
    end
    chk("busy", busy, m_owner >= 0);
    chk("out_valid", out_valid, e_valid);
    chk("in_ready", in_ready, e_ready);
    chk("grant_idx", grant_idx, m_gidx);
    chk("sop_err", sop_err, m_sop_err);
    s_valid   = in_valid;
    s_sop     = in_startofpacket;
    s_afull   = out_almost_full;
    s_acc     = e_valid && out_ready;
    s_acc_eop = 1'b0;
    if (s_acc) begin
      s_acc_eop = in_endofpacket[m_owner];
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {|out_data[DW-1:32], out_startofpacket, out_endofpacket, out_empty,
                     out_data[31:0]}, {1'b0, e});
      end
      if (out_startofpacket) sop_ports.push_back(int'(out_data[15:8]));
    end
`ifdef PKT_ARB_STATS_EN
    for (int i = 0; i < NUM_IN; i++) chk("pkt_count", pkt_count[i*32 +: 32], m_cnt[i]);
    chk("stall_cycles", stall_cycles, m_stall);
`endif
    o_valid = out_valid;
    o_acc   = out_valid & out_ready;
    o_sop   = out_valid & out_startofpacket;
    o_eop   = out_valid & out_endofpacket;
    o_busy  = busy;
  endtask

  task automatic advance();
    int p;
    if (m_owner < 0) begin
      if (s_valid != '0) begin
        if (!s_afull) begin
          p       = rr_next(m_last, s_valid);
          m_owner = p;
          m_gidx  = p;
          if (!s_sop[p]) m_sop_err = 1'b1;
        end else begin
          m_stall++;
        end
      end
    end else if (s_acc) begin
      void'(src_q[m_owner].pop_front());
      if (s_acc_eop) begin
        m_cnt[m_owner]++;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    advance();
    cyc++;
  endtask

  task automatic drain(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while ((exp_q.size() > 0 || m_owner >= 0) && n < 200);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_IN; i++) src_q[i].delete();
    exp_q.delete();
    sop_ports.delete();
    reset = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    reset     = 1'b0;
    m_owner   = -1;
    m_last    = NUM_IN - 1;
    m_gidx    = 0;
    m_sop_err = 1'b0;
    m_stall   = 0;
    for (int i = 0; i < NUM_IN; i++) m_cnt[i] = 0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int   n;
    int   cnt;
    logic any;
    logic [4:0] vpat, spat, epat, bpat;
    logic [IDX_W-1:0] g1;

    out_ready       = 1'b1;
    out_almost_full = 1'b0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_grant", grant_idx, 0);
    chk("rst_sop_err", sop_err, 0);

    // Ports 0,1,3 with two 2-beat packets each: order 0,1,3,0,1,3, 3 cycles per packet.
    for (int r = 0; r < 2; r++) begin
      push_pkt(0, r, 2, 1'b1);
      push_pkt(1, r, 2, 1'b1);
      push_pkt(3, r, 2, 1'b1);
    end
    for (int r = 0; r < 2; r++) begin
      expect_pkt(0, r, 2, 1'b1);
      expect_pkt(1, r, 2, 1'b1);
      expect_pkt(3, r, 2, 1'b1);
    end
    drain(n);
    chk("rr_cycles", n, 18);
    chk("rr_npkts", sop_ports.size(), 6);
    if (sop_ports.size() == 6) begin
      chk("rr_order0", sop_ports[0], 0);
      chk("rr_order1", sop_ports[1], 1);
      chk("rr_order2", sop_ports[2], 3);
      chk("rr_order3", sop_ports[3], 0);
      chk("rr_order4", sop_ports[4], 1);
      chk("rr_order5", sop_ports[5], 3);
    end

    // Port 2 alone, 3 beats: beats on cycles 1..3, busy drops after cycle 3.
    push_pkt(2, 9, 3, 1'b1);
    expect_pkt(2, 9, 3, 1'b1);
    vpat = '0; spat = '0; epat = '0; bpat = '0; g1 = '0;
    for (int c = 0; c < 5; c++) begin
      step();
      vpat[c] = o_valid;
      spat[c] = o_sop;
      epat[c] = o_eop;
      bpat[c] = o_busy;
      if (c == 1) g1 = grant_idx;
    end
    chk("p2_valid_pat", vpat, 5'b01110);
    chk("p2_sop_pat", spat, 5'b00010);
    chk("p2_eop_pat", epat, 5'b01000);
    chk("p2_busy_pat", bpat, 5'b01110);
    chk("p2_grant", g1, 2);

    // almost_full held before arbitration blocks the grant for 10 cycles.
    push_pkt(1, 3, 2, 1'b1);
    expect_pkt(1, 3, 2, 1'b1);
    out_almost_full = 1'b1;
    any = 1'b0;
    repeat (10) begin
      step();
      any = any | o_busy | o_valid;
    end
    chk("af_no_grant", any, 0);
`ifdef PKT_ARB_STATS_EN
    chk("af_stall_lit", stall_cycles, 10);
`endif
    out_almost_full = 1'b0;
    step();
    chk("af_arb_cycle_busy", o_busy, 0);
    step();
    chk("af_grant_busy", o_busy, 1);
    chk("af_grant_idx", grant_idx, 1);
    drain(n);

    // almost_full rises mid 5-beat packet on port 3: packet completes, port 0 waits.
    push_pkt(3, 4, 5, 1'b1);
    push_pkt(0, 5, 2, 1'b1);
    expect_pkt(3, 4, 5, 1'b1);
    expect_pkt(0, 5, 2, 1'b1);
    repeat (3) step();
    out_almost_full = 1'b1;
    cnt = 0;
    repeat (3) begin
      step();
      cnt += int'(o_acc);
    end
    chk("afm_beats_done", cnt, 3);
    any = 1'b0;
    repeat (5) begin
      step();
      any = any | o_busy | o_valid;
    end
    chk("afm_no_new_grant", any, 0);
    out_almost_full = 1'b0;
    drain(n);
    chk("afm_resume_cycles", n, 3);

    // out_ready toggles during a 4-beat packet on port 1.
    push_pkt(1, 6, 4, 1'b1);
    expect_pkt(1, 6, 4, 1'b1);
    n = 0;
    do begin
      out_ready = (n % 2 == 0);
      step();
      n++;
    end while ((exp_q.size() > 0 || m_owner >= 0) && n < 200);
    out_ready = 1'b1;
    chk("toggle_cycles", n, 9);

    // Missing SOP at arbitration sets a sticky error.
    push_pkt(0, 7, 2, 1'b0);
    expect_pkt(0, 7, 2, 1'b0);
    drain(n);
    chk("sop_err_set", sop_err, 1);
    push_pkt(1, 8, 3, 1'b1);
    expect_pkt(1, 8, 3, 1'b1);
    drain(n);
    chk("sop_err_sticky", sop_err, 1);

    // Reset mid-packet on port 2, then port 0 wins over port 3.
    push_pkt(2, 10, 4, 1'b1);
    expect_pkt(2, 10, 4, 1'b1);
    repeat (3) step();
    do_reset();
    chk("mrst_busy", busy, 0);
    chk("mrst_sop_err", sop_err, 0);
    chk("mrst_grant", grant_idx, 0);
    chk("mrst_out_valid", out_valid, 0);
`ifdef PKT_ARB_STATS_EN
    chk("mrst_pkt_count", pkt_count, 0);
`endif
    push_pkt(3, 11, 2, 1'b1);
    push_pkt(0, 12, 2, 1'b1);
    expect_pkt(0, 12, 2, 1'b1);
    expect_pkt(3, 11, 2, 1'b1);
    drain(n);
    chk("mrst_cycles", n, 6);
    chk("mrst_npkts", sop_ports.size(), 2);
    if (sop_ports.size() == 2) begin
      chk("mrst_first", sop_ports[0], 0);
      chk("mrst_second", sop_ports[1], 3);
    end
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_rr_arbiter.md
Name:
pkt_rr_arbiter

Overview:
- Merges NUM_IN Avalon-ST packet streams into one output stream. Sources are typically the out_* sides of single-clock packet FIFOs; the sink is typically a downstream packet FIFO.
- Arbitration is round-robin and packet-granular: once a packet is granted, it holds the output until its end-of-packet beat is accepted.
- A new grant is issued only while the downstream almost_full is low, so a sink running in USE_ALMOST_FULL mode never sees a new packet start after it asserts almost_full.

Parameters:
- NUM_IN, 4, number of input streams (2..16).
- SYMBOLS_PER_BEAT, 64, symbols per data beat.
- BITS_PER_SYMBOL, 8, bits per symbol; data width DW = SYMBOLS_PER_BEAT*BITS_PER_SYMBOL.
- IDX_W, $clog2(NUM_IN), width of the grant index (derived, not overridden).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*DW  packed input data; port i occupies bits [i*DW +: DW].
- in_valid  in  NUM_IN  per-port valid.
- in_ready  out  NUM_IN  per-port ready.
- in_startofpacket  in  NUM_IN  per-port SOP.
- in_endofpacket  in  NUM_IN  per-port EOP.
- in_empty  in  NUM_IN*6  per-port empty symbol count.
- out_data  out  DW  muxed output data.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream ready.
- out_startofpacket  out  1  output SOP.
- out_endofpacket  out  1  output EOP.
- out_empty  out  6  output empty symbol count.
- out_almost_full  in  1  downstream almost_full; blocks new grants only.
- grant_idx  out  IDX_W  index of the current or last granted port.
- busy  out  1  high while a packet is in flight.
- sop_err  out  1  sticky flag: a valid beat without SOP was presented at arbitration.

Behaviour:
- Reset: state=IDLE, rr_ptr=NUM_IN-1 (port 0 has first priority), grant_idx=0, busy=0, sop_err=0, in_ready=0, out_valid=0.
- Reset asserted mid-packet abandons the packet immediately; the next output beat must carry SOP.
- FSM has two states: IDLE and XFER.
- IDLE transitions:
  - Grant condition: out_almost_full==0 and at least one in_valid is set.
  - On grant, pick the first port j scanning rr_ptr+1, rr_ptr+2, ... modulo NUM_IN with in_valid[j]=1.
  - Register grant_idx=j and go to XFER. Arbitration costs one cycle; no beat is transferred in IDLE.
  - If the winning port has in_startofpacket[j]==0, still grant it and set sop_err (sticky until reset).
  - out_valid=0 and all in_ready=0 throughout IDLE.
- XFER behaviour:
  - Combinational pass-through: out_valid=in_valid[g], in_ready[g]=out_ready, and out_data/sop/eop/empty come from port g.
  - All other in_ready are 0.
  - Zero-cycle latency per beat; full throughput within a packet.
  - out_almost_full is ignored in XFER; a packet is never split.
- XFER to IDLE: taken on the cycle where in_valid[g] & out_ready & in_endofpacket[g]. On that edge rr_ptr<=g and busy falls.
- Steady-state cost per packet is packet beats + 1 cycle.
- busy = (state==XFER).
- A single-beat packet (SOP and EOP on the same beat) takes exactly 2 cycles: IDLE, then XFER.
- Valid inputs that never assert EOP hold the grant indefinitely; there is no timeout.
- Port-index wrap: the scan from rr_ptr=NUM_IN-1 starts at port 0.

Optional Feature:
- Macro: PKT_ARB_STATS_EN.
- Defined:
  - Adds output pkt_count, NUM_IN*32 bits, one counter per port.
  - A port's counter increments on each accepted EOP beat from that port and wraps at 2^32.
  - All counters reset to 0.
  - Adds output stall_cycles, 32 bits: increments every IDLE cycle where some in_valid=1 but out_almost_full=1.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Package pkt_arb_pkg holds:
  - typedef arb_state_t {IDLE, XFER};
  - localparam EMPTY_W=6.
- One sub-module rr_pick (combinational):
  - Inputs: req[NUM_IN], ptr[IDX_W].
  - Outputs: found, idx.
- The FSM, datapath mux and optional counters stay in the top module.

Test Plan:
- Port 2 only sends a 3-beat packet, out_ready=1: grant_idx=2, output beats appear at cycles 1-3 with SOP on beat 1 and EOP on beat 3; busy falls after cycle 3.
- Ports 0, 1 and 3 each continuously hold 2-beat packets: output order is 0,1,3,0,1,3, each packet followed by exactly 1 idle cycle.
- out_almost_full=1 from before arbitration while port 1 is valid: no grant and out_valid=0 for 10 cycles; grant occurs the cycle after almost_full drops.
- out_almost_full rises mid-packet on a 5-beat packet: all 5 beats complete; no new grant while it stays high.
- out_ready toggles 1,0,1,0 during a 4-beat packet: no beat is lost or duplicated; in_ready mirrors out_ready only on the granted port.
- Port 0 presents a valid beat without SOP at arbitration: sop_err=1 and stays 1 until reset. Reset asserted mid-packet: state returns to IDLE, the next grant goes to port 0 first, and with PKT_ARB_STATS_EN pkt_count clears to 0.
